// File: rtl/mul_sequencer_if.sv
// Request/response handshake bundle between issue logic, the multiply sequencer and writeback.
// master = issue/writeback side, slave = the sequencer.
interface mul_sequencer_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_op;
  logic [31:0]      req_rs1;
  logic [31:0]      req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             resp_valid;
  logic             resp_ready;
  logic [31:0]      resp_data;
  logic [TAG_W-1:0] resp_tag;

  modport master (
    output req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
    input  req_ready, resp_valid, resp_data, resp_tag
  );

  modport slave (
    input  req_valid, req_op, req_rs1, req_rs2, req_tag, resp_ready,
    output req_ready, resp_valid, resp_data, resp_tag
  );
endinterface

// File: rtl/mul_sequencer.sv
// Multi-cycle MUL/MULH/MULHSU/MULHU controller: 32 radix-2 partial products folded
// through a 3:2 carry-save compressor, then one 64-bit carry-propagate add.
module mul_sequencer #(
  parameter int TAG_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  output logic               busy,
  mul_sequencer_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    RESOLVE,
    DONE
  } state_t;

  state_t           state;
  logic [63:0]      sum_q;
  logic [63:0]      carry_q;
  logic [63:0]      a_ext_q;
  logic [31:0]      b_q;
  logic             b_signed_q;
  logic [1:0]       op_q;
  logic [TAG_W-1:0] tag_q;
  logic [4:0]       count_q;
  logic [31:0]      resp_data_q;
  logic [TAG_W-1:0] resp_tag_q;

  logic [63:0]      shifted;
  logic [63:0]      pp;
  logic [63:0]      sum_n;
  logic [63:0]      carry_n;
  logic [62:0]      maj;
  logic [63:0]      product;
  logic             inject;
  logic             a_signed;
  logic             zero_operand;

  assign bus.req_ready  = (state == IDLE) & ~rst & ~flush;
  assign bus.resp_valid = (state == DONE);
  assign bus.resp_data  = resp_data_q;
  assign bus.resp_tag   = resp_tag_q;
  assign busy           = (state != IDLE);

  assign a_signed     = (bus.req_op == 2'b01) | (bus.req_op == 2'b10);
  assign zero_operand = (bus.req_rs1 == 32'd0) | (bus.req_rs2 == 32'd0);

  // A signed multiplier's top bit weighs -2^31, so the last row is added as ~x + 1,
  // with the +1 slipped into the otherwise-empty carry bit 0.
  always_comb begin
    shifted = a_ext_q << count_q;
    inject  = (count_q == 5'd31) & b_signed_q & b_q[31];
    if (inject) begin
      pp = ~shifted;
    end else if (b_q[count_q]) begin
      pp = shifted;
    end else begin
      pp = 64'd0;
    end
    sum_n   = sum_q ^ carry_q ^ pp;
    maj     = (sum_q[62:0] & carry_q[62:0]) |
              (sum_q[62:0] & pp[62:0])      |
              (carry_q[62:0] & pp[62:0]);
    carry_n = {maj, inject};
    product = sum_q + carry_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      sum_q       <= 64'd0;
      carry_q     <= 64'd0;
      a_ext_q     <= 64'd0;
      b_q         <= 32'd0;
      b_signed_q  <= 1'b0;
      op_q        <= 2'b00;
      tag_q       <= '0;
      count_q     <= 5'd0;
      resp_data_q <= 32'd0;
      resp_tag_q  <= '0;
    end else if (flush) begin
      state   <= IDLE;
      sum_q   <= 64'd0;
      carry_q <= 64'd0;
      count_q <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid & bus.req_ready) begin
            op_q       <= bus.req_op;
            tag_q      <= bus.req_tag;
            a_ext_q    <= a_signed ? {{32{bus.req_rs1[31]}}, bus.req_rs1}
                                   : {32'd0, bus.req_rs1};
            b_q        <= bus.req_rs2;
            b_signed_q <= (bus.req_op == 2'b01);
            sum_q      <= 64'd0;
            carry_q    <= 64'd0;
            count_q    <= 5'd0;
            // Any zero operand makes the product zero; skip the accumulate entirely.
            if (zero_operand) begin
              resp_data_q <= 32'd0;
              resp_tag_q  <= bus.req_tag;
              state       <= DONE;
            end else begin
              state <= ACCUM;
            end
          end
        end
        ACCUM: begin
          sum_q   <= sum_n;
          carry_q <= carry_n;
          count_q <= count_q + 5'd1;
          if (count_q == 5'd31) begin
            state <= RESOLVE;
          end
        end
        RESOLVE: begin
          resp_data_q <= (op_q == 2'b00) ? product[31:0] : product[63:32];
          resp_tag_q  <= tag_q;
          state       <= DONE;
        end
        DONE: begin
          if (bus.resp_ready) begin
            state <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: doc/mul_sequencer.md
# mul_sequencer

Multi-cycle controller for the M-extension multiplier datapath. It accepts one MUL/MULH/MULHSU/MULHU request at a time and sequences 32 radix-2 partial products through a 64-bit 3:2 carry-save compressor into a sum/carry accumulator pair. It then resolves the pair with one 64-bit carry-propagate add and returns the selected 32-bit half. It sits between the execute-stage issue logic and writeback, with a valid/ready handshake on both sides and a flush input for pipeline kills.

## Interface
- TAG_W, 5: width of the opaque request tag (destination register index), returned unchanged with the result.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  kill any in-flight or pending operation.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept; equals (state==IDLE) & ~rst & ~flush.
- req_op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (funct3[1:0]).
- req_rs1  in  32  multiplicand a.
- req_rs2  in  32  multiplier b.
- req_tag  in  TAG_W  request tag.
- resp_valid  out  1  result available.
- resp_ready  in  1  consumer takes the result.
- resp_data  out  32  result.
- resp_tag  out  TAG_W  tag of the returned result.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, ACCUM, RESOLVE, DONE. Reset and flush both force IDLE. A flush in the same cycle as req_valid means no accept.
- Accept: req_valid & req_ready. The block latches op and tag.
  - a_ext (64b): a is sign-extended for MULH and MULHSU, zero-extended otherwise.
  - b is signed only for MULH.
  - sum, carry, and count are cleared to 0.
- Zero skip: if rs1==0 or rs2==0 at accept, go IDLE->DONE with product=0.
- ACCUM, one partial product per cycle, count i = 0..31:
  - pp = b[i] ? (a_ext << i) : 0, truncated to 64b.
  - Exception: when i==31, b is signed, and b[31]==1, pp = ~(a_ext << 31). The +1 of the negation is injected into carry bit 0 for that cycle.
  - Compressor: sum' = sum^carry^pp; carry' = {maj(sum,carry,pp)[62:0], 1'b0}, with bit 0 replaced by the injection when applicable.
  - count increments by 1. After the i==31 update, go to RESOLVE.
- RESOLVE: product = sum + carry, mod 2^64, via the 64b CPA. Register the selected half: [31:0] for MUL, [63:32] for the others. Go to DONE.
- DONE: resp_valid=1. resp_data and resp_tag stay stable until resp_ready. On resp_valid & resp_ready, go to IDLE. Results are never dropped except by flush or rst.
- Arithmetic requirement: product equals the exact mathematical product of the interpreted operands, mod 2^64.

## Timing
- Reset values: resp_valid=0, resp_data=0, resp_tag=0, busy=0, req_ready=0 while rst is high. req_ready=1 the cycle after rst deasserts.
- Accept at the edge ending cycle 0:
  - ACCUM in cycles 1..32.
  - RESOLVE in cycle 33.
  - resp_valid first high in cycle 34.
- Zero skip: resp_valid high in cycle 1.
- With resp_ready held high: one result per 35 cycles, or per 2 cycles for zero-skip. No accept while in DONE, even if resp_ready is high that cycle. The next accept is possible no earlier than the cycle after the handshake.
- Backpressure: DONE holds indefinitely with outputs unchanged.
- Flush or rst in any state:
  - state becomes IDLE, resp_valid=0, and accumulators are cleared on the next edge.
  - A result in DONE is discarded.
  - flush and resp_ready in the same cycle: flush wins, and the consumer must treat the result as not taken.
- req_* inputs are ignored outside the accept cycle. Changing rs1/rs2 mid-operation has no effect.

## Test plan
- MUL 3 x 5, resp_ready=1 -> resp_data=0x0000000F, tag echoed, resp_valid exactly 34 cycles after accept, busy high cycles 1..34.
- MULH 0x80000000 x 0x80000000 -> 0x40000000. MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000. MULH 0x00000002 x 0xFFFFFFFD -> 0xFFFFFFFF (exercises the signed-b injection).
- MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF. MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE. MUL 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000001.
- Zero skip: MULHU 0 x 0x12345678 -> resp_valid in cycle 1 with data 0. Back-to-back: second request accepted in cycle 2.
- Backpressure: resp_ready low for 10 cycles after resp_valid -> data and tag stable, req_ready=0 throughout. resp_ready high -> IDLE, and req_ready=1 the next cycle.
- Flush at cycle 15 of ACCUM, then rst at cycle 20 of a new operation -> IDLE next cycle, no resp_valid, and the following MUL 7 x 6 returns 0x0000002A with correct latency.
- Random regression over all four ops against a 64b reference model, including 0x80000000, 0x7FFFFFFF, 1, and -1 corners.
